// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand bypass selection plus ID-stage stall generation for
// load-use, pending multi-cycle results and multi-cycle unit occupancy.
module hazard_forward_ctrl #(
    parameter int REG_AW  = 5,
    parameter int NSRC    = 2,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic                   id_mul,
    input  logic [REG_AW-1:0]      idex_rd,
    input  logic                   idex_regwrite,
    input  logic                   idex_memread,
    input  logic                   idex_mul,
    input  logic [NSRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]      exmem_rd,
    input  logic                   exmem_regwrite,
    input  logic [REG_AW-1:0]      memwb_rd,
    input  logic                   memwb_regwrite,
    output logic [2*NSRC-1:0]      fwd_sel,
    output logic                   stall,
    output logic                   flush_idex,
    output logic                   mul_busy,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               sb_valid_q, sb_valid_d;
    logic [REG_AW-1:0]  sb_rd_q, sb_rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]    ld_hit;
    logic [NSRC-1:0]    sb_hit;
    logic               busy;
    logic               lu;
    logic               raw_mul;
    logic               st_mul;
    logic               stall_w;

    assign busy = (cnt_q != '0);

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [REG_AW-1:0] ers;
        logic [REG_AW-1:0] irs;
        logic              exm_hit;
        logic              mwb_hit;
        logic              irs_live;

        assign ers = ex_rs[k*REG_AW +: REG_AW];
        assign irs = id_rs[k*REG_AW +: REG_AW];

        assign exm_hit = exmem_regwrite && (exmem_rd != '0)
                         && (exmem_rd == ers);
        assign mwb_hit = memwb_regwrite && (memwb_rd != '0)
                         && (memwb_rd == ers);

        // EX/MEM holds the younger value, so it beats MEM/WB
        assign fwd_sel[2*k +: 2] = reset   ? 2'b00 :
                                   exm_hit ? 2'b10 :
                                   mwb_hit ? 2'b01 : 2'b00;

        assign irs_live  = id_rs_used[k] && (irs != '0);
        assign ld_hit[k] = irs_live && (irs == idex_rd);
        assign sb_hit[k] = irs_live && (irs == sb_rd_q);
    end

    assign lu      = idex_memread && idex_regwrite && (|ld_hit);
    assign raw_mul = busy && sb_valid_q && (|sb_hit);
    assign st_mul  = id_mul && (busy || idex_mul);
    assign stall_w = !reset && (lu || raw_mul || st_mul);

    assign stall      = stall_w;
    assign flush_idex = stall_w;
    assign mul_busy   = !reset && busy;
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        state_d    = state_q;
        sb_valid_d = sb_valid_q;
        sb_rd_d    = sb_rd_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (idex_mul) begin
                    state_d    = BUSY;
                    sb_valid_d = idex_regwrite && (idex_rd != '0);
                    sb_rd_d    = idex_rd;
                    cnt_d      = CW'(MUL_LAT - 1);
                end
            end
            BUSY: begin
                // a new idex_mul here is structurally impossible; drop it
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = IDLE;
                    sb_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sb_valid_q  <= 1'b0;
            sb_rd_q     <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sb_valid_q  <= sb_valid_d;
            sb_rd_q     <= sb_rd_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: vector table, directed multi-cycle
// sequences and random traffic against a cycle-indexed reference model.
module tb_hazard_forward_ctrl;

    localparam int REG_AW  = 5;
    localparam int NSRC    = 2;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        id_mul;
    logic [4:0]  idex_rd;
    logic        idex_regwrite;
    logic        idex_memread;
    logic        idex_mul;
    logic [9:0]  ex_rs;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        flush_idex;
    logic        mul_busy;
    logic [3:0]  stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: cycle index of the last accepted MUL
    int         cyc = 0;
    int         t0 = 0;
    bit         have_mul = 0;
    bit         dest_v = 0;
    logic [4:0] dest = '0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .REG_AW (REG_AW),
        .NSRC   (NSRC),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rs_used    (id_rs_used),
        .id_mul        (id_mul),
        .idex_rd       (idex_rd),
        .idex_regwrite (idex_regwrite),
        .idex_memread  (idex_memread),
        .idex_mul      (idex_mul),
        .ex_rs         (ex_rs),
        .exmem_rd      (exmem_rd),
        .exmem_regwrite(exmem_regwrite),
        .memwb_rd      (memwb_rd),
        .memwb_regwrite(memwb_regwrite),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .flush_idex    (flush_idex),
        .mul_busy      (mul_busy),
        .stall_cnt     (stall_cnt)
    );

    typedef struct {
        logic [4:0] ers0, ers1, exm_rd;
        logic       exm_we;
        logic [4:0] mwb_rd;
        logic       mwb_we;
        logic [4:0] irs0, irs1;
        logic [1:0] used;
        logic [4:0] ld_rd;
        logic       ld;
        logic [3:0] xfwd;
        logic       xstall;
    } vec_t;

    function automatic vec_t mkv(int e0, int e1, int xr, int xw,
                                 int mr, int mw, int i0, int i1,
                                 int u, int lr, int l, int f, int s);
        vec_t v;
        v.ers0 = 5'(e0);   v.ers1 = 5'(e1);
        v.exm_rd = 5'(xr); v.exm_we = 1'(xw);
        v.mwb_rd = 5'(mr); v.mwb_we = 1'(mw);
        v.irs0 = 5'(i0);   v.irs1 = 5'(i1);
        v.used = 2'(u);    v.ld_rd = 5'(lr);
        v.ld = 1'(l);      v.xfwd = 4'(f);
        v.xstall = 1'(s);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit m_busy();
        return have_mul && (cyc > t0) && (cyc < t0 + MUL_LAT);
    endfunction

    function automatic bit m_match(logic [4:0] r);
        bit hit = 0;
        for (int k = 0; k < NSRC; k++)
            if (id_rs_used[k] && r != 0 && r == id_rs[k*5 +: 5]) hit = 1;
        return hit;
    endfunction

    function automatic logic [3:0] m_fwd();
        logic [3:0] f = '0;
        logic [4:0] r;
        if (reset) return '0;
        for (int k = 0; k < NSRC; k++) begin
            r = ex_rs[k*5 +: 5];
            if (exmem_regwrite && exmem_rd != 0 && exmem_rd == r)
                f[2*k +: 2] = 2'b10;
            else if (memwb_regwrite && memwb_rd != 0 && memwb_rd == r)
                f[2*k +: 2] = 2'b01;
        end
        return f;
    endfunction

    function automatic bit m_stall();
        bit lu, raw, st;
        if (reset) return 0;
        lu  = idex_memread && idex_regwrite && m_match(idex_rd);
        raw = m_busy() && dest_v && m_match(dest);
        st  = id_mul && (m_busy() || idex_mul);
        return lu || raw || st;
    endfunction

    task automatic settle();
        #1;
        chk("mdl_fwd", 32'(fwd_sel), 32'(m_fwd()));
        chk("mdl_stall", 32'(stall), 32'(m_stall()));
        chk("mdl_flush", 32'(flush_idex), 32'(m_stall()));
        chk("mdl_busy", 32'(mul_busy), 32'(m_busy() && !reset));
        chk("mdl_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic edge_();
        bit s, b;
        s = m_stall();
        b = m_busy();
        @(posedge clk);
        if (reset) begin
            have_mul = 0;
            m_cnt = 0;
        end else begin
            if (s && m_cnt < CMAX) m_cnt++;
            if (idex_mul && !b) begin
                have_mul = 1;
                t0 = cyc;
                dest = idex_rd;
                dest_v = idex_regwrite && idex_rd != 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        settle();
        edge_();
    endtask

    task automatic idle_in();
        id_rs = '0; id_rs_used = '0; id_mul = 0;
        idex_rd = '0; idex_regwrite = 0; idex_memread = 0;
        idex_mul = 0; ex_rs = '0;
        exmem_rd = '0; exmem_regwrite = 0;
        memwb_rd = '0; memwb_regwrite = 0;
    endtask

    task automatic reset_dut();
        idle_in();
        reset = 1;
        edge_();
        reset = 0;
    endtask

    vec_t vt[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = mkv(5,1,5,1,5,1, 0,0,0, 0,0, 4'b0010,0);
        vt[1] = mkv(5,1,6,1,5,1, 0,0,0, 0,0, 4'b0001,0);
        vt[2] = mkv(0,0,0,1,0,1, 0,0,0, 0,0, 4'b0000,0);
        vt[3] = mkv(5,0,5,0,5,1, 0,0,0, 0,0, 4'b0001,0);
        vt[4] = mkv(7,7,7,1,2,1, 0,0,0, 0,0, 4'b1010,0);
        vt[5] = mkv(3,4,3,1,4,1, 0,0,0, 0,0, 4'b0110,0);
        vt[6] = mkv(0,0,0,0,0,0, 2,7,3, 7,1, 4'b0000,1);
        vt[7] = mkv(0,0,0,0,0,0, 2,7,1, 7,1, 4'b0000,0);
        vt[8] = mkv(0,0,0,0,0,0, 0,0,3, 0,1, 4'b0000,0);
        vt[9] = mkv(0,0,0,0,0,0, 7,0,1, 7,0, 4'b0000,0);

        // forwarding selects are zero while reset is held
        idle_in();
        reset = 1;
        ex_rs = {5'd5, 5'd5};
        exmem_rd = 5'd5; exmem_regwrite = 1;
        idex_mul = 1;
        #1;
        chk("rst_fwd", 32'(fwd_sel), 0);
        chk("rst_stall", 32'(stall), 0);
        edge_();
        reset = 0;
        idle_in();
        settle();
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_busy", 32'(mul_busy), 0);
        edge_();

        foreach (vt[i]) begin
            idle_in();
            ex_rs = {vt[i].ers1, vt[i].ers0};
            exmem_rd = vt[i].exm_rd; exmem_regwrite = vt[i].exm_we;
            memwb_rd = vt[i].mwb_rd; memwb_regwrite = vt[i].mwb_we;
            id_rs = {vt[i].irs1, vt[i].irs0};
            id_rs_used = vt[i].used;
            idex_rd = vt[i].ld_rd;
            idex_memread = vt[i].ld; idex_regwrite = vt[i].ld;
            settle();
            chk($sformatf("vec%0d_fwd", i), 32'(fwd_sel), 32'(vt[i].xfwd));
            chk($sformatf("vec%0d_stall", i), 32'(stall),
                32'(vt[i].xstall));
            edge_();
        end

        // load-use: one bubble, then the freed pipeline proceeds
        reset_dut();
        idle_in();
        idex_rd = 5'd7; idex_memread = 1; idex_regwrite = 1;
        id_rs = {5'd7, 5'd2}; id_rs_used = 2'b11;
        settle();
        chk("lu_stall", 32'(stall), 1);
        chk("lu_flush", 32'(flush_idex), 1);
        edge_();
        idex_rd = '0; idex_memread = 0; idex_regwrite = 0;
        settle();
        chk("lu_release", 32'(stall), 0);
        chk("lu_cnt", 32'(stall_cnt), 1);
        edge_();
        idex_rd = 5'd7; idex_memread = 1; idex_regwrite = 1;
        id_rs_used = 2'b01;
        settle();
        chk("lu_unused", 32'(stall), 0);
        edge_();

        // dependent reader behind a MUL waits MUL_LAT-1 cycles
        reset_dut();
        idle_in();
        idex_mul = 1; idex_rd = 5'd9; idex_regwrite = 1;
        step();
        idle_in();
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            settle();
            chk($sformatf("mul_raw%0d", i), 32'(stall), 1);
            chk($sformatf("mul_busy%0d", i), 32'(mul_busy), 1);
            edge_();
        end
        settle();
        chk("mul_free", 32'(stall), 0);
        chk("mul_free_busy", 32'(mul_busy), 0);
        chk("mul_cnt", 32'(stall_cnt), MUL_LAT - 1);
        edge_();
        idle_in();
        ex_rs = {5'd0, 5'd9}; exmem_rd = 5'd9; exmem_regwrite = 1;
        settle();
        chk("mul_fwd", 32'(fwd_sel[1:0]), 2);
        edge_();

        // independent mul behind mul is held by the structural hazard
        reset_dut();
        idle_in();
        idex_mul = 1; idex_rd = 5'd3; idex_regwrite = 1;
        id_mul = 1; id_rs = {5'd1, 5'd2}; id_rs_used = 2'b11;
        settle();
        chk("st_first", 32'(stall), 1);
        edge_();
        idle_in();
        id_mul = 1; id_rs = {5'd1, 5'd2}; id_rs_used = 2'b11;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            settle();
            chk($sformatf("st_hold%0d", i), 32'(stall), 1);
            edge_();
        end
        settle();
        chk("st_free", 32'(stall), 0);
        chk("st_cnt", 32'(stall_cnt), MUL_LAT);
        edge_();
        idle_in();
        idex_mul = 1; idex_rd = 5'd4; idex_regwrite = 1;
        step();
        idle_in();
        settle();
        chk("st_second_busy", 32'(mul_busy), 1);
        edge_();
        for (int i = 0; i < 3; i++) step();

        // load-use coinciding with a pending-MUL dependency
        reset_dut();
        idle_in();
        idex_mul = 1; idex_rd = 5'd4; idex_regwrite = 1;
        step();
        idle_in();
        idex_rd = 5'd6; idex_memread = 1; idex_regwrite = 1;
        id_rs = {5'd6, 5'd4}; id_rs_used = 2'b11;
        settle();
        chk("dual_stall", 32'(stall), 1);
        edge_();
        idex_rd = '0; idex_memread = 0; idex_regwrite = 0;
        settle();
        chk("dual_cnt1", 32'(stall_cnt), 1);
        chk("dual_raw", 32'(stall), 1);
        edge_();
        step();
        settle();
        chk("dual_free", 32'(stall), 0);
        chk("dual_cnt3", 32'(stall_cnt), 3);
        edge_();

        // reset in the middle of a MUL abandons it
        reset_dut();
        idle_in();
        idex_mul = 1; idex_rd = 5'd9; idex_regwrite = 1;
        step();
        idle_in();
        id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        step();
        reset = 1;
        settle();
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_busy", 32'(mul_busy), 0);
        edge_();
        reset = 0;
        settle();
        chk("postrst_busy", 32'(mul_busy), 0);
        chk("postrst_stall", 32'(stall), 0);
        chk("postrst_cnt", 32'(stall_cnt), 0);
        edge_();

        // counter saturation
        idle_in();
        idex_rd = 5'd7; idex_memread = 1; idex_regwrite = 1;
        id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        for (int i = 0; i < 20; i++) step();
        settle();
        chk("sat_cnt", 32'(stall_cnt), CMAX);
        edge_();

        // random traffic against the model
        reset_dut();
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            id_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_rs_used = 2'($urandom);
            id_mul = ($urandom_range(0, 4) == 0);
            idex_rd = 5'($urandom_range(0, 3));
            idex_regwrite = 1'($urandom);
            idex_memread = ($urandom_range(0, 3) == 0);
            idex_mul = ($urandom_range(0, 4) == 0);
            ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            exmem_rd = 5'($urandom_range(0, 3));
            exmem_regwrite = 1'($urandom);
            memwb_rd = 5'($urandom_range(0, 3));
            memwb_regwrite = 1'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
